// File: rtl/demux2_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
// The optional delivered-beat counters are enabled by defining DEMUX2_COUNT_EN.
package demux2_pkg;

  localparam int unsigned DEMUX2_DEPTH = 2;
  localparam int unsigned DEMUX2_CNT_W = 16;
  localparam int unsigned DEMUX2_WIDTH = 8;

  // Occupancy of one 2-entry FIFO, 0..2
  typedef logic [1:0] occ_t;

  localparam occ_t OccEmpty = 2'd0;
  localparam occ_t OccFull  = 2'd2;

  // Next occupancy given already-qualified push/pop strobes.
  function automatic occ_t occ_next(occ_t occ, logic push, logic pop);
    occ_t res;
    res = occ;
    unique case ({push, pop})
      2'b10:   res = occ + 2'd1;
      2'b01:   res = occ - 2'd1;
      default: res = occ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/demux2_stream_if.sv
// Handshake bundle of demux2_stream: one input stream plus select, two output streams.
// slave is the demultiplexer's view; master is the producer/consumer side.
interface demux2_stream_if #(
  parameter int unsigned WIDTH = 8
);

  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_bits;
  logic             io_S;

  logic             io_Y0_valid;
  logic             io_Y0_ready;
  logic [WIDTH-1:0] io_Y0_bits;

  logic             io_Y1_valid;
  logic             io_Y1_ready;
  logic [WIDTH-1:0] io_Y1_bits;

  modport slave (
    input  io_in_valid,
    output io_in_ready,
    input  io_in_bits,
    input  io_S,
    output io_Y0_valid,
    input  io_Y0_ready,
    output io_Y0_bits,
    output io_Y1_valid,
    input  io_Y1_ready,
    output io_Y1_bits
  );

  modport master (
    output io_in_valid,
    input  io_in_ready,
    output io_in_bits,
    output io_S,
    input  io_Y0_valid,
    output io_Y0_ready,
    input  io_Y0_bits,
    input  io_Y1_valid,
    output io_Y1_ready,
    input  io_Y1_bits
  );

endinterface

// File: rtl/demux2_fifo2.sv
// Two-entry FIFO with 1-bit pointers and explicit occupancy; head reads as zero when empty.
// Reset clears storage as well, so nothing of a discarded beat survives.
module demux2_fifo2
  import demux2_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX2_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEMUX2_DEPTH];
  logic [WIDTH-1:0] mem_d [DEMUX2_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  occ_t             occ_q, occ_d;
  logic             push_ok, pop_ok;

  assign full_o  = (occ_q == OccFull);
  assign empty_o = (occ_q == OccEmpty);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Strobes are qualified locally so a misbehaving caller cannot corrupt occupancy.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_next(occ_q, push_ok, pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEMUX2_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= OccEmpty;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer with an independent 2-entry FIFO per output.
// Defining DEMUX2_COUNT_EN adds 16-bit wrapping delivered-beat counters io_cnt0/io_cnt1.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX2_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  demux2_stream_if.slave          bus_io
`ifdef DEMUX2_COUNT_EN
  ,
  output logic [DEMUX2_CNT_W-1:0] io_cnt0,
  output logic [DEMUX2_CNT_W-1:0] io_cnt1
`endif
);

  logic             full0, full1;
  logic             empty0, empty1;
  logic [WIDTH-1:0] head0, head1;
  logic             push0, push1;
  logic             pop0, pop1;
  logic             in_fire;

  // Ready looks only at the selected FIFO, never at the consumers.
  assign bus_io.io_in_ready = bus_io.io_S ? ~full1 : ~full0;

  assign in_fire = bus_io.io_in_valid & bus_io.io_in_ready;
  assign push0   = in_fire & ~bus_io.io_S;
  assign push1   = in_fire & bus_io.io_S;

  assign bus_io.io_Y0_valid = ~empty0;
  assign bus_io.io_Y1_valid = ~empty1;
  assign bus_io.io_Y0_bits  = head0;
  assign bus_io.io_Y1_bits  = head1;

  assign pop0 = ~empty0 & bus_io.io_Y0_ready;
  assign pop1 = ~empty1 & bus_io.io_Y1_ready;

  demux2_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo0 (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push0),
    .data_i  (bus_io.io_in_bits),
    .pop_i   (pop0),
    .full_o  (full0),
    .empty_o (empty0),
    .head_o  (head0)
  );

  demux2_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo1 (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push1),
    .data_i  (bus_io.io_in_bits),
    .pop_i   (pop1),
    .full_o  (full1),
    .empty_o (empty1),
    .head_o  (head1)
  );

`ifdef DEMUX2_COUNT_EN
  logic [DEMUX2_CNT_W-1:0] cnt0_q, cnt0_d;
  logic [DEMUX2_CNT_W-1:0] cnt1_q, cnt1_d;

  // Natural modulo-2^16 arithmetic provides the FFFF -> 0 wrap.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) cnt0_d = cnt0_q + DEMUX2_CNT_W'(1);
    if (pop1) cnt1_d = cnt1_q + DEMUX2_CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign io_cnt0 = cnt0_q;
  assign io_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Directed self-checking bench for demux2_stream; counter checks compile in with DEMUX2_COUNT_EN.
module tb_demux2_stream;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  demux2_stream_if #(.WIDTH(8)) bus ();

`ifdef DEMUX2_COUNT_EN
  logic [15:0] cnt0, cnt1;
  demux2_stream #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus_io  (bus),
    .io_cnt0 (cnt0),
    .io_cnt1 (cnt1)
  );
`else
  demux2_stream #(.WIDTH(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; all driving and sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    bus.io_in_valid  = 1'b0;
    bus.io_in_bits   = 8'h00;
    bus.io_S         = 1'b0;
    bus.io_Y0_ready  = 1'b0;
    bus.io_Y1_ready  = 1'b0;
    #12;
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.io_in_ready); end
    checks++; if (bus.io_Y0_valid !== 1'b0) begin errors++; $display("FAIL rst_y0_valid got %b exp 0", bus.io_Y0_valid); end
    checks++; if (bus.io_Y1_valid !== 1'b0) begin errors++; $display("FAIL rst_y1_valid got %b exp 0", bus.io_Y1_valid); end
    checks++; if (bus.io_Y0_bits !== 8'h00) begin errors++; $display("FAIL rst_y0_bits got %h exp 00", bus.io_Y0_bits); end
    checks++; if (bus.io_Y1_bits !== 8'h00) begin errors++; $display("FAIL rst_y1_bits got %h exp 00", bus.io_Y1_bits); end
`ifdef DEMUX2_COUNT_EN
    checks++; if (cnt0 !== 16'h0) begin errors++; $display("FAIL rst_cnt0 got %h exp 0000", cnt0); end
    checks++; if (cnt1 !== 16'h0) begin errors++; $display("FAIL rst_cnt1 got %h exp 0000", cnt1); end
`endif
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_route();
    bus.io_Y0_ready = 1'b1;
    bus.io_Y1_ready = 1'b1;
    bus.io_in_valid = 1'b1;
    bus.io_in_bits  = 8'hA5;
    bus.io_S        = 1'b0;
    #1;
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL route_ready0 got %b exp 1", bus.io_in_ready); end
    checks++; if (bus.io_Y0_valid !== 1'b0) begin errors++; $display("FAIL route_no_comb_path got %b exp 0", bus.io_Y0_valid); end
    tick();
    bus.io_in_bits = 8'h3C;
    bus.io_S       = 1'b1;
    #1;
    checks++; if (bus.io_Y0_valid !== 1'b1) begin errors++; $display("FAIL route_y0_valid got %b exp 1", bus.io_Y0_valid); end
    checks++; if (bus.io_Y0_bits !== 8'hA5) begin errors++; $display("FAIL route_y0_bits got %h exp a5", bus.io_Y0_bits); end
    checks++; if (bus.io_Y1_valid !== 1'b0) begin errors++; $display("FAIL route_y1_early got %b exp 0", bus.io_Y1_valid); end
    tick();
    bus.io_in_valid = 1'b0;
    #1;
    checks++; if (bus.io_Y0_valid !== 1'b0) begin errors++; $display("FAIL route_y0_once got %b exp 0", bus.io_Y0_valid); end
    checks++; if (bus.io_Y1_valid !== 1'b1) begin errors++; $display("FAIL route_y1_valid got %b exp 1", bus.io_Y1_valid); end
    checks++; if (bus.io_Y1_bits !== 8'h3C) begin errors++; $display("FAIL route_y1_bits got %h exp 3c", bus.io_Y1_bits); end
    tick();
    checks++; if (bus.io_Y1_valid !== 1'b0) begin errors++; $display("FAIL route_y1_once got %b exp 0", bus.io_Y1_valid); end
  endtask

  task automatic test_backpressure();
    bus.io_Y0_ready = 1'b0;
    bus.io_Y1_ready = 1'b0;
    bus.io_in_valid = 1'b1;
    bus.io_S        = 1'b0;
    bus.io_in_bits  = 8'h01;
    #1;
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept01 got %b exp 1", bus.io_in_ready); end
    tick();
    bus.io_in_bits = 8'h02;
    #1;
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept02 got %b exp 1", bus.io_in_ready); end
    tick();
    bus.io_in_bits = 8'h03;
    #1;
    checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", bus.io_in_ready); end
    tick();
    checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full got %b exp 0", bus.io_in_ready); end
    checks++; if (bus.io_Y0_bits !== 8'h01) begin errors++; $display("FAIL bp_y0_head got %h exp 01", bus.io_Y0_bits); end
    bus.io_S       = 1'b1;
    bus.io_in_bits = 8'h77;
    #1;
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready got %b exp 1", bus.io_in_ready); end
    tick();
    bus.io_in_valid = 1'b0;
    bus.io_Y1_ready = 1'b1;
    #1;
    checks++; if (bus.io_Y1_valid !== 1'b1) begin errors++; $display("FAIL bp_y1_valid got %b exp 1", bus.io_Y1_valid); end
    checks++; if (bus.io_Y1_bits !== 8'h77) begin errors++; $display("FAIL bp_y1_bits got %h exp 77", bus.io_Y1_bits); end
    tick();
    bus.io_Y0_ready = 1'b1;
    bus.io_in_valid = 1'b1;
    bus.io_S        = 1'b0;
    bus.io_in_bits  = 8'h03;
    #1;
    checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_full_ready got %b exp 0", bus.io_in_ready); end
    checks++; if (bus.io_Y0_bits !== 8'h01) begin errors++; $display("FAIL bp_first_out got %h exp 01", bus.io_Y0_bits); end
    tick();
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b exp 1", bus.io_in_ready); end
    checks++; if (bus.io_Y0_bits !== 8'h02) begin errors++; $display("FAIL bp_second_out got %h exp 02", bus.io_Y0_bits); end
    tick();
    bus.io_in_valid = 1'b0;
    #1;
    checks++; if (bus.io_Y0_valid !== 1'b1) begin errors++; $display("FAIL bp_third_valid got %b exp 1", bus.io_Y0_valid); end
    checks++; if (bus.io_Y0_bits !== 8'h03) begin errors++; $display("FAIL bp_third_out got %h exp 03", bus.io_Y0_bits); end
    tick();
    checks++; if (bus.io_Y0_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", bus.io_Y0_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bits;
    bus.io_Y1_ready = 1'b1;
    bus.io_S        = 1'b1;
    bus.io_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.io_in_bits = 8'h10 + 8'(i);
      #1;
      checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, bus.io_in_ready); end
      if (i > 0) begin
        exp_bits = 8'h0F + 8'(i);
        checks++; if (bus.io_Y1_valid !== 1'b1 || bus.io_Y1_bits !== exp_bits) begin
          errors++; $display("FAIL b2b_out[%0d] got %b/%h exp 1/%h", i, bus.io_Y1_valid, bus.io_Y1_bits, exp_bits);
        end
      end
      tick();
    end
    bus.io_in_valid = 1'b0;
    #1;
    checks++; if (bus.io_Y1_valid !== 1'b1 || bus.io_Y1_bits !== 8'h1F) begin
      errors++; $display("FAIL b2b_last got %b/%h exp 1/1f", bus.io_Y1_valid, bus.io_Y1_bits);
    end
    tick();
    checks++; if (bus.io_Y1_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", bus.io_Y1_valid); end
  endtask

  task automatic test_mid_reset();
    bus.io_Y0_ready = 1'b0;
    bus.io_S        = 1'b0;
    bus.io_in_valid = 1'b1;
    bus.io_in_bits  = 8'hC1;
    tick();
    bus.io_in_bits = 8'hC2;
    tick();
    bus.io_in_valid = 1'b0;
    #1;
    checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("FAIL mr_full got %b exp 0", bus.io_in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (bus.io_Y0_valid !== 1'b0) begin errors++; $display("FAIL mr_valid_async got %b exp 0", bus.io_Y0_valid); end
    checks++; if (bus.io_Y0_bits !== 8'h00) begin errors++; $display("FAIL mr_bits_async got %h exp 00", bus.io_Y0_bits); end
    checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL mr_ready_async got %b exp 1", bus.io_in_ready); end
    @(negedge clock);
    reset           = 1'b1;
    bus.io_Y0_ready = 1'b1;
    tick();
    checks++; if (bus.io_Y0_valid !== 1'b0) begin errors++; $display("FAIL mr_no_stale got %b exp 0", bus.io_Y0_valid); end
    tick();
    checks++; if (bus.io_Y0_valid !== 1'b0) begin errors++; $display("FAIL mr_no_stale2 got %b exp 0", bus.io_Y0_valid); end
  endtask

`ifdef DEMUX2_COUNT_EN
  task automatic test_counters();
    reset = 1'b0;
    #2;
    @(negedge clock);
    reset           = 1'b1;
    bus.io_Y0_ready = 1'b1;
    bus.io_Y1_ready = 1'b1;
    tick();
    bus.io_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.io_S       = (i >= 3);
      bus.io_in_bits = 8'(i);
      tick();
    end
    bus.io_in_valid = 1'b0;
    tick();
    tick();
    checks++; if (cnt0 !== 16'd3) begin errors++; $display("FAIL cnt0_three got %0d exp 3", cnt0); end
    checks++; if (cnt1 !== 16'd5) begin errors++; $display("FAIL cnt1_five got %0d exp 5", cnt1); end
    bus.io_S        = 1'b0;
    bus.io_in_valid = 1'b1;
    for (int i = 0; i < 65532; i++) begin
      tick();
    end
    bus.io_in_valid = 1'b0;
    tick();
    tick();
    checks++; if (cnt0 !== 16'hFFFF) begin errors++; $display("FAIL cnt0_max got %h exp ffff", cnt0); end
    bus.io_in_valid = 1'b1;
    tick();
    bus.io_in_valid = 1'b0;
    tick();
    tick();
    checks++; if (cnt0 !== 16'h0000) begin errors++; $display("FAIL cnt0_wrap got %h exp 0000", cnt0); end
    checks++; if (cnt1 !== 16'd5) begin errors++; $display("FAIL cnt1_hold got %0d exp 5", cnt1); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_route();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
`ifdef DEMUX2_COUNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
# demux2_stream

Registered 1-to-2 stream demultiplexer: the routing counterpart of the 2:1 mux block. It accepts one valid/ready input stream with a per-beat select bit and steers each beat into one of two output streams. Each output has its own 2-entry FIFO, so a stalled output never blocks beats destined for the other output once they are queued. It sits between a single producer and two consumers in the datapath.

## Interface
- WIDTH, 8, data bits per beat
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- io_in_valid  in  1  input beat valid
- io_in_ready  out  1  input beat accepted when valid & ready
- io_in_bits  in  WIDTH  input data
- io_S  in  1  destination select, sampled with the beat (0 → Y0, 1 → Y1)
- io_Y0_valid / io_Y1_valid  out  1  output beat valid
- io_Y0_ready / io_Y1_ready  in  1  consumer ready
- io_Y0_bits / io_Y1_bits  out  WIDTH  output data (FIFO head)
- io_cnt0 / io_cnt1  out  16  delivered-beat counters (only with DEMUX2_COUNT_EN)

## Operation
- Push: beat accepted when io_in_valid & io_in_ready; written to FIFO[io_S].
- io_in_ready = !full[io_S]. Combinational in io_S and FIFO state only; never depends on io_Yx_ready.
- Pop: FIFO x pops when io_Yx_valid & io_Yx_ready. io_Yx_valid = !empty[x]. io_Yx_bits = head entry; WIDTH'h0 when the FIFO is empty.
- Per FIFO: 2 entries, 1-bit write/read pointers, 2-bit occupancy (0..2). Pointers wrap 1→0.
- Simultaneous push and pop, same FIFO, occupancy 1: both occur; occupancy stays 1.
- Full FIFO (occupancy 2) with pop this cycle: push refused (ready was 0); occupancy goes to 1.
- Empty FIFO: pop impossible (valid 0); push makes occupancy 1.
- Order is preserved per output. No ordering guarantee between outputs.
- io_S is ignored when io_in_valid = 0.

## Timing
- Latency: a beat accepted in cycle N is visible on io_Yx_valid/bits in cycle N+1. There is no combinational in→out path.
- Throughput: 1 beat/cycle sustained when the selected consumer holds ready high.
- Reset (asynchronous assert, synchronous release edge into clock domain):
  - All pointers and occupancies 0.
  - io_Y0_valid = io_Y1_valid = 0; io_Yx_bits = 0; io_in_ready = 1.
  - Counters 0.
- Reset asserted mid-operation: queued beats are discarded immediately, with no partial state retained.

## Configuration
- DEMUX2_COUNT_EN defined:
  - io_cnt0/io_cnt1 exist.
  - Each increments by 1 on every pop of its FIFO and wraps 16'hFFFF → 0.
  - Reset value 0.
- DEMUX2_COUNT_EN undefined: counter ports and logic are absent. Data behaviour is identical.

## Structure
- Package demux2_pkg:
  - DEMUX2_DEPTH = 2
  - DEMUX2_CNT_W = 16
  - default WIDTH
  - occupancy typedef (2 bits)
- Sub-module demux2_fifo2:
  - parameterised 2-entry FIFO with push/pop/full/empty/head
  - instantiated twice

## Test plan
- Reset: hold reset=0 → io_in_ready=1, both valid=0, bits=0, counters=0.
- Route: push 0xA5 with S=0, then 0x3C with S=1, both consumers ready → 0xA5 on Y0 in cycle 1, 0x3C on Y1 in cycle 2, each for exactly one beat.
- Backpressure/full: Y0_ready=0, push 0x01, 0x02, 0x03 with S=0:
  - 0x01 and 0x02 accepted; io_in_ready=0 while S=0.
  - Switch S=1, push 0x77 → accepted and appears on Y1.
  - Release Y0 → 0x01 then 0x02, then 0x03 is accepted.
- Simultaneous push/pop at occupancy 1 on Y1 → occupancy stays 1; streaming 0x10..0x1F delivers in order at 1 beat/cycle.
- Mid-operation reset: two beats queued in Y0, pulse reset low for a half cycle → Y0_valid=0 immediately; no stale beat after release.
- DEMUX2_COUNT_EN: deliver 3 beats to Y0 and 5 to Y1 → io_cnt0=3, io_cnt1=5. Preload io_cnt0 to 16'hFFFF via 65535 pops, then one more pop → io_cnt0=0.
